sqrt_arbiter: RTL
=================

Name: sqrt_arbiter

Overview:
- Shares one pipelined fixed-point square-root datapath between two requesters (FPU lanes 0 and 1).
- Round-robin issue, one operand per cycle; the no-stall datapath is driven directly.
- Each in-flight operation is tagged with its owner; results are steered into per-requester result FIFOs.
- Credit-based issue guarantees a returning result always has buffer space.

Parameters:
- WIDTH, 26, operand/result width; must match the datapath.
- STAGES, 6, datapath stage count; must be >= 2. Latency LAT = STAGES-1 (local constant, not a parameter).
- RES_DEPTH, 4, entries per requester result FIFO; must be >= 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- r0_valid  in  1  requester 0 operand valid
- r0_ready  out  1  requester 0 operand accepted this cycle
- r0_data  in  WIDTH  requester 0 operand
- r1_valid / r1_ready / r1_data  same as above, requester 1
- sq_in  out  WIDTH  operand driven to the datapath input
- sq_out  in  WIDTH  datapath normalized root
- sq_sticky  in  1  datapath inexact flag
- o0_valid  out  1  result available for requester 0
- o0_ready  in  1  requester 0 consumes the result
- o0_data  out  WIDTH  result root
- o0_sticky  out  1  result sticky
- o1_valid / o1_ready / o1_data / o1_sticky  same as above, requester 1
- busy  out  1  any op in flight or any FIFO non-empty

Behaviour:
- Reset (async, rst=1): tag pipeline cleared; both FIFOs empty; credits = RES_DEPTH; RR pointer favours requester 0.
  - Outputs under reset: r*_ready=0, o*_valid=0, o*_data=0, o*_sticky=0, sq_in=0, busy=0.
- Eligibility: requester i is eligible when ri_valid=1 and credit_i>0.
  - One eligible: grant it.
  - Both eligible: grant the one not granted last; the pointer updates only on a grant.
- Handshake: ri_ready = grant_i, combinational, and does not depend on ri_valid beyond eligibility.
  - Transfer occurs when valid&&ready.
  - Requesters hold data stable while valid and not ready.
- sq_in = granted ri_data, combinational; 0 when there is no grant.
  - Operand issued in cycle t: the result is on sq_out/sq_sticky in cycle t+LAT.
- Tag pipeline: LAT-entry shift register of {valid, id}.
  - Entry 0 loads {grant_any, grant_id} each clock.
  - When the last entry is valid, sq_out/sq_sticky are pushed into FIFO[id] on that clock edge.
- Credit:
  - credit_i = RES_DEPTH - occupancy_i - inflight_i, held as a counter.
  - Issue decrements; FIFO pop (oi_valid&&oi_ready) increments.
  - Simultaneous issue and pop: no change.
  - Credit never negative, never above RES_DEPTH.
- FIFO: first-word-fall-through.
  - oi_valid = not empty; oi_data/oi_sticky show the head entry.
  - Push and pop in the same cycle are allowed at any occupancy, including full (the credit scheme ensures no overflow) and empty (pop ignored since oi_valid=0).
  - Pointers wrap modulo RES_DEPTH.
- Ordering: results per requester are returned in issue order; there is no ordering between requesters.
- Throughput: one issue per cycle total; a single requester alone reaches one per cycle while credit lasts.
- Reset mid-operation: stale data still inside the datapath is discarded because its tags were cleared; no spurious oi_valid after reset.
- busy = |tag valids | ~empty0 | ~empty1.

Optional Feature:
- Macro SQRT_ARB_PERF_EN.
- Defined:
  - Add outputs perf_issue0, perf_issue1, perf_stall0, perf_stall1, each 32 bits.
  - Issue counters count grants per requester.
  - Stall counters count cycles with ri_valid=1 and ri_ready=0.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fpu_pkg: requester id type (1 bit), result-entry struct {data[WIDTH], sticky}, and constant SQRT_LAT(STAGES)=STAGES-1.
- One sub-module sqrt_res_fifo (parameters WIDTH, DEPTH), instantiated twice.
- Arbiter, credit counters and tag pipeline stay in the top module.
- The datapath is instantiated outside the block, at FPU top.

Test Plan:
- Reset: rst=1 for 3 cycles with r0_valid=1 -> r0_ready=0, o0_valid=0, busy=0, sq_in=0; after release r0 is granted in the first cycle.
- Single op: r0_data=0 issued at cycle t -> o0_valid rises at t+LAT+1 (STAGES=6: t+6) with o0_data=0 and o0_sticky=0; busy falls after the pop.
- Fairness: r0_valid=r1_valid=1 continuously with both o*_ready=1 -> grants alternate 0,1,0,1; 8 ops each in 16 cycles; results match the golden sqrt model in issue order per requester.
- Credit backpressure: o0_ready=0, r0_valid=1 -> exactly RES_DEPTH=4 issues, then r0_ready stays 0.
  - r1 is still granted every cycle.
  - Raising o0_ready for one cycle pops one entry and one more r0 issue follows.
- Full FIFO push/pop: FIFO0 at 3 entries with 1 in flight; the last entry arrives in the same cycle as a pop -> occupancy stays 3, and data order is preserved.
- Reset mid-flight: 3 ops in flight, then pulse rst -> no oi_valid for the following LAT+2 cycles with both r*_valid=0; credits are back to 4.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types for the square-root arbiter: requester id, result entry and
// the datapath latency helper.
package fpu_pkg;

  localparam int FPU_WIDTH = 26;

  typedef logic req_id_t;

  typedef struct packed {
    logic [FPU_WIDTH-1:0] data;
    logic                 sticky;
  } sqrt_res_t;

  // An operand issued in cycle t shows its root on the datapath output in t+LAT.
  function automatic int SQRT_LAT(input int stages);
    return stages - 1;
  endfunction

endpackage

// File: rtl/sqrt_res_fifo.sv
// First-word-fall-through result FIFO for one requester; holds {sticky, root}.
// Push and pop may coincide at any occupancy; a pop while empty is ignored.
module sqrt_res_fifo
  import fpu_pkg::*;
#(
  parameter int WIDTH = FPU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_sticky_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             sticky_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pop_en;
  logic [WIDTH:0]  head;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_en = pop_i && (cnt_q != '0);
    wr_d   = push_i ? wrap_inc(wr_q) : wr_q;
    rd_d   = pop_en ? wrap_inc(rd_q) : rd_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // When full, the write slot equals the head being popped on the same edge.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= {push_sticky_i, push_data_i};
  end

  always_comb begin
    head     = mem_q[rd_q];
    valid_o  = (cnt_q != '0);
    data_o   = valid_o ? head[WIDTH-1:0] : '0;
    sticky_o = valid_o ? head[WIDTH] : 1'b0;
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin, credit-based sharing of one pipelined square-root datapath between
// two FPU lanes. Optional perf counters are enabled by defining SQRT_ARB_PERF_EN.
module sqrt_arbiter
  import fpu_pkg::*;
#(
  parameter int WIDTH     = FPU_WIDTH,
  parameter int STAGES    = 6,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_data,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_data,
  output logic [WIDTH-1:0] sq_in,
  input  logic [WIDTH-1:0] sq_out,
  input  logic             sq_sticky,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o0_sticky,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [WIDTH-1:0] o1_data,
  output logic             o1_sticky,
  output logic             busy
`ifdef SQRT_ARB_PERF_EN
  ,
  output logic [31:0]      perf_issue0,
  output logic [31:0]      perf_issue1,
  output logic [31:0]      perf_stall0,
  output logic [31:0]      perf_stall1
`endif
);

  localparam int LAT = SQRT_LAT(STAGES);
  localparam int CW  = $clog2(RES_DEPTH + 1);

  logic [CW-1:0] cred0_q, cred0_d, cred1_q, cred1_d;
  req_id_t       last_q, last_d;
  logic          elig0, elig1, grant0, grant1, grant_any;
  req_id_t       grant_id;
  logic          pop0, pop1, push0, push1, tag_any;
  logic          tag_vld_q [LAT];
  req_id_t       tag_id_q  [LAT];

  // Arbitration: reset forces no grant so nothing is accepted while rst is high.
  always_comb begin
    elig0     = !rst && r0_valid && (cred0_q != '0);
    elig1     = !rst && r1_valid && (cred1_q != '0);
    grant0    = elig0 && (!elig1 || last_q == 1'b1);
    grant1    = elig1 && (!elig0 || last_q == 1'b0);
    grant_any = grant0 || grant1;
    grant_id  = req_id_t'(grant1);
    r0_ready  = grant0;
    r1_ready  = grant1;
    sq_in     = grant0 ? r0_data : (grant1 ? r1_data : '0);
    last_d    = grant0 ? 1'b0 : (grant1 ? 1'b1 : last_q);
  end

  always_comb begin
    pop0    = o0_valid && o0_ready;
    pop1    = o1_valid && o1_ready;
    cred0_d = cred0_q;
    cred1_d = cred1_q;
    case ({grant0, pop0})
      2'b10:   cred0_d = cred0_q - 1'b1;
      2'b01:   cred0_d = cred0_q + 1'b1;
      default: cred0_d = cred0_q;
    endcase
    case ({grant1, pop1})
      2'b10:   cred1_d = cred1_q - 1'b1;
      2'b01:   cred1_d = cred1_q + 1'b1;
      default: cred1_d = cred1_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred0_q <= CW'(RES_DEPTH);
      cred1_q <= CW'(RES_DEPTH);
      last_q  <= 1'b1;
    end else begin
      cred0_q <= cred0_d;
      cred1_q <= cred1_d;
      last_q  <= last_d;
    end
  end

  // Tag pipeline: clearing the valids on reset drops whatever is still in the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_vld_q[i] <= 1'b0;
    end else begin
      tag_vld_q[0] <= grant_any;
      for (int i = 1; i < LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant_id;
    for (int i = 1; i < LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  always_comb begin
    push0   = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == 1'b0);
    push1   = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == 1'b1);
    tag_any = 1'b0;
    for (int i = 0; i < LAT; i++) tag_any = tag_any | tag_vld_q[i];
    busy    = tag_any | o0_valid | o1_valid;
  end

  sqrt_res_fifo #(.WIDTH(WIDTH), .DEPTH(RES_DEPTH)) u_fifo0 (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push0),
    .push_data_i   (sq_out),
    .push_sticky_i (sq_sticky),
    .pop_i         (o0_ready),
    .valid_o       (o0_valid),
    .data_o        (o0_data),
    .sticky_o      (o0_sticky)
  );

  sqrt_res_fifo #(.WIDTH(WIDTH), .DEPTH(RES_DEPTH)) u_fifo1 (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push1),
    .push_data_i   (sq_out),
    .push_sticky_i (sq_sticky),
    .pop_i         (o1_ready),
    .valid_o       (o1_valid),
    .data_o        (o1_data),
    .sticky_o      (o1_sticky)
  );

`ifdef SQRT_ARB_PERF_EN
  logic [31:0] perf_issue0_q, perf_issue1_q, perf_stall0_q, perf_stall1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue0_q <= '0;
      perf_issue1_q <= '0;
      perf_stall0_q <= '0;
      perf_stall1_q <= '0;
    end else begin
      if (grant0) perf_issue0_q <= perf_issue0_q + 1'b1;
      if (grant1) perf_issue1_q <= perf_issue1_q + 1'b1;
      if (r0_valid && !r0_ready) perf_stall0_q <= perf_stall0_q + 1'b1;
      if (r1_valid && !r1_ready) perf_stall1_q <= perf_stall1_q + 1'b1;
    end
  end

  assign perf_issue0 = perf_issue0_q;
  assign perf_issue1 = perf_issue1_q;
  assign perf_stall0 = perf_stall0_q;
  assign perf_stall1 = perf_stall1_q;
`endif

endmodule
